// File: rtl/dsram_axi_slave.sv
// Data-SRAM responder for the LSU memory port.
// AXI-lite style slave with independent read and write FSMs and a programmable
// per-access latency that models slow memory.
module dsram_axi_slave #(
  parameter int unsigned            ADDR_W    = 32,
  parameter int unsigned            DATA_W    = 32,
  parameter int unsigned            STRB_W    = 8,
  parameter int unsigned            DEPTH     = 4096,
  parameter logic [ADDR_W-1:0]      BASE_ADDR = 32'h8000_0000,
  parameter int unsigned            RD_LAT    = 2,
  parameter int unsigned            WR_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Word address is the offset from the base with the byte-lane bits dropped.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rd_sample;
  logic [ADDR_W-1:0] rd_addr;

  assign arready = rst && (r_state_q == RIdle);
  assign rvalid  = (r_state_q == RResp);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // Read next-state: accept AR, count down latency, sample RAM on the last wait cycle.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    araddr_d  = araddr_q;
    rd_sample = 1'b0;
    rd_addr   = araddr_q;
    case (r_state_q)
      RIdle: begin
        if (arvalid && arready) begin
          araddr_d = araddr;
          if (RD_LAT == 0) begin
            rd_sample = 1'b1;
            rd_addr   = araddr;
            r_state_d = RResp;
          end else begin
            r_cnt_d   = 4'(RD_LAT);
            r_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (r_cnt_q == 4'd1) begin
          rd_sample = 1'b1;
          r_state_d = RResp;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      RResp: if (rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rd_sample) begin
      rdata_d = in_range(rd_addr) ? mem[idx_of(rd_addr)] : '0;
      rresp_d = in_range(rd_addr) ? OKAY : SLVERR;
    end
  end

  // Read state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= RIdle;
      r_cnt_q   <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [3:0]        w_cnt_q, w_cnt_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [STRB_W-1:0] c_strb;
  logic              unused_strb;

  assign awready     = rst && (w_state_q == WIdle) && !aw_got_q;
  assign wready      = rst && (w_state_q == WIdle) && !w_got_q;
  assign bvalid      = (w_state_q == WResp);
  assign bresp       = bresp_q;
  assign unused_strb = ^c_strb[STRB_W-1:NBYTES];

  // Write next-state: collect AW and W in any order, then wait and commit.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    c_addr    = awaddr_q;
    c_data    = wdata_q;
    c_strb    = wstrb_q;
    case (w_state_q)
      WIdle: begin
        if (awvalid && awready) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (wvalid && wready) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_got_d && w_got_d) begin
          if (WR_LAT == 0) begin
            commit    = 1'b1;
            c_addr    = awaddr_d;
            c_data    = wdata_d;
            c_strb    = wstrb_d;
            w_state_d = WResp;
          end else begin
            w_cnt_d   = 4'(WR_LAT);
            w_state_d = WWait;
          end
        end
      end
      WWait: begin
        if (w_cnt_q == 4'd1) begin
          commit    = 1'b1;
          w_state_d = WResp;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      WResp: begin
        if (bready) begin
          w_state_d = WIdle;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      default: w_state_d = WIdle;
    endcase
    if (commit) bresp_d = in_range(c_addr) ? OKAY : SLVERR;
  end

  // Write state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= WIdle;
      w_cnt_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // RAM byte-lane commit; not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && in_range(c_addr)) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (c_strb[i]) mem[idx_of(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

endmodule
